// File: rtl/regfile_bypass_sb_pkg.sv
// regfile_pkg: shared constants for the bypassing register file.
//   DEF_DATA_W : default register width in bits
//   DEF_ADDR_W : default register address width (NREG = 2**ADDR_W)
//   ZERO_ADDR  : address of the hard-wired zero register
package regfile_pkg;

  localparam int DEF_DATA_W = 32'sd32;
  localparam int DEF_ADDR_W = 32'sd5;
  localparam int ZERO_ADDR  = 32'sd0;

endpackage : regfile_pkg

// File: rtl/regfile_bypass_sb_if.sv
// regfile_bypass_sb_if: groups the read, writeback, issue, hazard and debug
// signals of the register file.
//   master : pipeline side (drives addresses, writeback, issue)
//   slave  : register file side (returns read data, busy flags, debug data)
interface regfile_bypass_sb_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);

  logic [ADDR_W-1:0] rd_addr1;
  logic [ADDR_W-1:0] rd_addr2;
  logic [DATA_W-1:0] data1;
  logic [DATA_W-1:0] data2;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              issue_valid;
  logic [ADDR_W-1:0] issue_dst;
  logic              busy1;
  logic              busy2;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_data;

  modport master (
    output rd_addr1, rd_addr2, wr_en, wr_addr, wr_data,
           issue_valid, issue_dst, dbg_addr,
    input  data1, data2, busy1, busy2, dbg_data
  );

  modport slave (
    input  rd_addr1, rd_addr2, wr_en, wr_addr, wr_data,
           issue_valid, issue_dst, dbg_addr,
    output data1, data2, busy1, busy2, dbg_data
  );

endinterface : regfile_bypass_sb_if

// File: rtl/regfile_bypass_sb_scoreboard.sv
// regfile_scoreboard: one pending-write bit per register plus hazard flags.
//   clk, reset            : clock, synchronous active-high reset
//   issue_valid/issue_dst : sets pending[issue_dst]
//   wr_en/wr_addr         : clears pending[wr_addr] (issue wins on a tie)
//   rd_addr1/rd_addr2     : read addresses to check for hazards
//   busy1/busy2           : combinational hazard flags per read port
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = 32'sd1,
  parameter int BYPASS   = 32'sd1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_dst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic              busy1,
  output logic              busy2
);

  localparam int              NREG      = 32'sd1 << ADDR_W;
  localparam bit              ZERO_EN   = (ZERO_REG != 32'sd0);
  localparam bit              BYPASS_EN = (BYPASS != 32'sd0);
  localparam logic [ADDR_W-1:0] ZERO_A  = ADDR_W'(ZERO_ADDR);

  logic [NREG-1:0] pending_r;
  logic [NREG-1:0] pending_nxt_s;

  // Next pending state: a new producer (set) supersedes a retiring one (clear).
  always_comb begin
    pending_nxt_s = pending_r;
    for (int i = 32'sd0; i < NREG; i++) begin
      if (ZERO_EN && (ADDR_W'(i) == ZERO_A)) begin
        pending_nxt_s[i] = 1'b0;
      end else if (issue_valid && (issue_dst == ADDR_W'(i))) begin
        pending_nxt_s[i] = 1'b1;
      end else if (wr_en && (wr_addr == ADDR_W'(i))) begin
        pending_nxt_s[i] = 1'b0;
      end else begin
        pending_nxt_s[i] = pending_r[i];
      end
    end
  end

  // Pending-bit register with synchronous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_r <= {NREG{1'b0}};
    end else begin
      pending_r <= pending_nxt_s;
    end
  end

  // Hazard flags: a same-cycle writeback only resolves the hazard when it
  // can be forwarded into the read register.
  always_comb begin
    busy1 = pending_r[rd_addr1] & ~(wr_en & (wr_addr == rd_addr1) & BYPASS_EN);
    busy2 = pending_r[rd_addr2] & ~(wr_en & (wr_addr == rd_addr2) & BYPASS_EN);
    if (ZERO_EN && (rd_addr1 == ZERO_A)) begin
      busy1 = 1'b0;
    end else begin
      busy1 = busy1;
    end
    if (ZERO_EN && (rd_addr2 == ZERO_A)) begin
      busy2 = 1'b0;
    end else begin
      busy2 = busy2;
    end
  end

endmodule : regfile_scoreboard

// File: rtl/regfile_bypass_sb.sv
// regfile_bypass_sb: two-read/one-write register file with registered reads,
// optional same-edge write-through bypass, optional hard-wired zero register,
// a pending-write scoreboard and an addressable debug tap.
//   clk   : clock, all state updates on posedge
//   reset : synchronous active-high reset of all architectural state
//   bus   : regfile_bypass_sb_if.slave (reads, writeback, issue, busy, debug)
module regfile_bypass_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = 32'sd1,
  parameter int BYPASS   = 32'sd1
) (
  input logic                clk,
  input logic                reset,
  regfile_bypass_sb_if.slave bus
);

  localparam int              NREG      = 32'sd1 << ADDR_W;
  localparam bit              ZERO_EN   = (ZERO_REG != 32'sd0);
  localparam bit              BYPASS_EN = (BYPASS != 32'sd0);
  localparam logic [ADDR_W-1:0] ZERO_A  = ADDR_W'(ZERO_ADDR);

  logic [DATA_W-1:0] regs_r [NREG];
  logic [DATA_W-1:0] data1_r;
  logic [DATA_W-1:0] data2_r;
  logic [DATA_W-1:0] rd1_nxt_s;
  logic [DATA_W-1:0] rd2_nxt_s;
  logic [DATA_W-1:0] dbg_s;
  logic              wr_ok_s;
  logic              busy1_s;
  logic              busy2_s;

  // Value a read port captures at this edge: zero register, forwarded
  // writeback, or the stored contents, in that priority.
  function automatic logic [DATA_W-1:0] read_sel(
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] stored,
    input logic              wr_ok,
    input logic [ADDR_W-1:0] waddr,
    input logic [DATA_W-1:0] wdata
  );
    logic [DATA_W-1:0] val;
    if (ZERO_EN && (addr == ZERO_A)) begin
      val = {DATA_W{1'b0}};
    end else if (BYPASS_EN && wr_ok && (waddr == addr)) begin
      val = wdata;
    end else begin
      val = stored;
    end
    return val;
  endfunction

  // Write qualification and read/debug selection.
  always_comb begin
    wr_ok_s   = bus.wr_en & ~(ZERO_EN & (bus.wr_addr == ZERO_A));
    rd1_nxt_s = read_sel(bus.rd_addr1, regs_r[bus.rd_addr1], wr_ok_s, bus.wr_addr, bus.wr_data);
    rd2_nxt_s = read_sel(bus.rd_addr2, regs_r[bus.rd_addr2], wr_ok_s, bus.wr_addr, bus.wr_data);
    if (ZERO_EN && (bus.dbg_addr == ZERO_A)) begin
      dbg_s = {DATA_W{1'b0}};
    end else begin
      dbg_s = regs_r[bus.dbg_addr];
    end
  end

  // Storage array and read-data registers; reset wins over any writeback.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 32'sd0; i < NREG; i++) begin
        regs_r[i] <= {DATA_W{1'b0}};
      end
      data1_r <= {DATA_W{1'b0}};
      data2_r <= {DATA_W{1'b0}};
    end else begin
      if (wr_ok_s) begin
        regs_r[bus.wr_addr] <= bus.wr_data;
      end
      data1_r <= rd1_nxt_s;
      data2_r <= rd2_nxt_s;
    end
  end

  regfile_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG),
    .BYPASS   (BYPASS)
  ) u_sb (
    .clk         (clk),
    .reset       (reset),
    .issue_valid (bus.issue_valid),
    .issue_dst   (bus.issue_dst),
    .wr_en       (bus.wr_en),
    .wr_addr     (bus.wr_addr),
    .rd_addr1    (bus.rd_addr1),
    .rd_addr2    (bus.rd_addr2),
    .busy1       (busy1_s),
    .busy2       (busy2_s)
  );

  assign bus.data1    = data1_r;
  assign bus.data2    = data2_r;
  assign bus.busy1    = busy1_s;
  assign bus.busy2    = busy2_s;
  assign bus.dbg_data = dbg_s;

endmodule : regfile_bypass_sb
